stage_link_fifo: RTL

STAGE_LINK_FIFO -- requirements
Module: stage_link_fifo

---
 rtl/stage_link_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stage_link_fifo.sv
// Inter-stage link: independent first-word-fall-through FIFOs for PHVs and VLAN IDs,
// plus a one-cycle register slice on the control AXI-Stream path.

module stage_link_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;
    logic             drop;

    // Handshakes depend only on the registered occupancy, never on the consumer side
    assign din_ready  = (count != CW'(DEPTH));
    assign dout_valid = (count != {CW{1'b0}});
    assign dout       = mem[rd_ptr];
    assign wr_en      = din_valid && din_ready;
    assign rd_en      = dout_valid && dout_ready;
    assign drop       = din_valid && !din_ready;

    // Storage array; contents are left untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr   <= {AW{1'b0}};
            rd_ptr   <= {AW{1'b0}};
            count    <= {CW{1'b0}};
            drop_cnt <= 16'h0000;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
        end
    end
endmodule

module stage_link_fifo #(
    parameter int PHV_LEN              = 32*64+256,
    parameter int C_VLANID_WIDTH       = 12,
    parameter int DEPTH                = 4,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axis_clk,
    input  logic                              areset,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_ready_out,
    input  logic [C_VLANID_WIDTH-1:0]         vlan_in,
    input  logic                              vlan_valid_in,
    output logic                              vlan_ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              stage_ready_in,
    output logic [C_VLANID_WIDTH-1:0]         vlan_out,
    output logic                              vlan_valid_out,
    input  logic                              vlan_out_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [15:0]                       phv_drop_cnt,
    output logic [15:0]                       vlan_drop_cnt
);
    stage_link_fifo_buf #(
        .WIDTH (PHV_LEN),
        .DEPTH (DEPTH)
    ) u_phv_fifo (
        .clk        (axis_clk),
        .areset     (areset),
        .din        (phv_in),
        .din_valid  (phv_in_valid),
        .din_ready  (phv_ready_out),
        .dout       (phv_out),
        .dout_valid (phv_out_valid),
        .dout_ready (stage_ready_in),
        .drop_cnt   (phv_drop_cnt)
    );

    stage_link_fifo_buf #(
        .WIDTH (C_VLANID_WIDTH),
        .DEPTH (DEPTH)
    ) u_vlan_fifo (
        .clk        (axis_clk),
        .areset     (areset),
        .din        (vlan_in),
        .din_valid  (vlan_valid_in),
        .din_ready  (vlan_ready_out),
        .dout       (vlan_out),
        .dout_valid (vlan_valid_out),
        .dout_ready (vlan_out_ready),
        .drop_cnt   (vlan_drop_cnt)
    );

    // Control path: plain one-cycle register slice, no backpressure
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            c_m_axis_tdata  <= {C_S_AXIS_DATA_WIDTH{1'b0}};
            c_m_axis_tuser  <= {C_S_AXIS_TUSER_WIDTH{1'b0}};
            c_m_axis_tkeep  <= {(C_S_AXIS_DATA_WIDTH/8){1'b0}};
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tdata  <= c_s_axis_tdata;
            c_m_axis_tuser  <= c_s_axis_tuser;
            c_m_axis_tkeep  <= c_s_axis_tkeep;
            c_m_axis_tvalid <= c_s_axis_tvalid;
            c_m_axis_tlast  <= c_s_axis_tlast;
        end
    end
endmodule
